// File: rtl/kempston_mouse_ext.sv
// kempston_mouse_ext: PS/2 (HPS ps2_mouse packet) to Kempston mouse port.
// Accumulates X/Y deltas into CNT_W-bit position counters and presents the
// X, Y and button bytes on the CPU I/O read path. It also provides:
//   - a coherent X->Y read snapshot,
//   - sticky button latches, so short presses survive until the next poll.
//
// Optional feature: define KEMPSTON_WHEEL_EN to add a 4-bit wheel counter in
// bits [7:4] of the button byte.
//
// Ports:
//   clk_sys        system clock, all state changes on the rising edge
//   reset          synchronous, active-high reset
//   ps2_mouse      HPS packet: [24] toggle, [23:16] dY, [15:8] dX,
//                  [5] Y sign, [4] X sign, [2:0] M/R/L buttons
//   ps2_mouse_ext  HPS extension; [3:0] wheel delta (wheel build only)
//   addr           port address bits
//   rd             one-cycle read strobe, qualified by sel
//   sel            1 when addr decodes to a mouse port
//   dout           read data, combinational from registered state
module kempston_mouse_ext #(
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned SENS_SHIFT = 0,
    parameter bit          INVERT_Y   = 1'b0,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [24:0] ps2_mouse,
    input  logic [15:0] ps2_mouse_ext,
    input  logic [2:0]  addr,
    input  logic        rd,
    output logic        sel,
    output logic [7:0]  dout
);

    localparam int unsigned EXT_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CX_RST = CNT_W'(32'd128 << SENS_SHIFT);

    logic [CNT_W-1:0] cx;
    logic [CNT_W-1:0] cy;
    logic             old_toggle;
    logic             snap_valid;
    logic [7:0]       y_snap;
    logic [2:0]       btn;        // live buttons from the last packet, packet order
    logic [2:0]       btn_latch;  // sticky presses, packet order (bit0 L, bit1 R, bit2 M)

    logic             event_c;
    logic [EXT_W-1:0] dx_ext;
    logic [EXT_W-1:0] dy_ext;
    logic [EXT_W-1:0] dy_eff;
    logic             rd_x_c;
    logic             rd_y_c;
    logic             rd_b_c;
    logic [2:0]       held;
    logic [7:0]       btn_byte;
    logic [7:0]       x_byte;
    logic [7:0]       y_byte;

    // Add a signed delta; bit CNT_W of the unsigned sum flags over/underflow.
    function automatic logic [CNT_W-1:0] accum(input logic [CNT_W-1:0] cur,
                                               input logic [EXT_W-1:0] d);
        logic [EXT_W-1:0] s;
        s = {1'b0, cur} + d;
        if (SATURATE && s[CNT_W]) begin
            return d[CNT_W] ? '0 : '1;
        end
        return s[CNT_W-1:0];
    endfunction

    assign event_c = ps2_mouse[24] != old_toggle;
    assign dx_ext  = EXT_W'($signed({ps2_mouse[4], ps2_mouse[15:8]}));
    assign dy_ext  = EXT_W'($signed({ps2_mouse[5], ps2_mouse[23:16]}));
    assign dy_eff  = INVERT_Y ? (EXT_W'(0) - dy_ext) : dy_ext;

    assign x_byte = cx[SENS_SHIFT +: 8];
    assign y_byte = snap_valid ? y_snap : cy[SENS_SHIFT +: 8];
    assign held   = btn | btn_latch;

`ifdef KEMPSTON_WHEEL_EN
    logic [3:0] wheel;
    assign btn_byte = {wheel, 1'b1, ~held[0], ~held[2], ~held[1]};
    wire unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3], ps2_mouse_ext[15:4]};
`else
    assign btn_byte = {5'b11111, ~held[0], ~held[2], ~held[1]};
    wire unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3], ps2_mouse_ext};
`endif

    // Port decode and read mux.
    always_comb begin
        sel    = 1'b0;
        dout   = 8'hFF;
        rd_x_c = 1'b0;
        rd_y_c = 1'b0;
        rd_b_c = 1'b0;
        if (addr == 3'b011) begin
            sel    = 1'b1;
            dout   = x_byte;
            rd_x_c = rd;
        end else if (addr == 3'b111) begin
            sel    = 1'b1;
            dout   = y_byte;
            rd_y_c = rd;
        end else if (addr[1:0] == 2'b10) begin
            sel    = 1'b1;
            dout   = btn_byte;
            rd_b_c = rd;
        end
    end

    // Position, snapshot and button state.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cx         <= CX_RST;
            cy         <= '0;
            old_toggle <= ps2_mouse[24];
            snap_valid <= 1'b0;
            y_snap     <= '0;
            btn        <= '0;
            btn_latch  <= '0;
        end else begin
            old_toggle <= ps2_mouse[24];
            if (event_c) begin
                cx  <= accum(cx, dx_ext);
                cy  <= accum(cy, dy_eff);
                btn <= ps2_mouse[2:0];
            end
            if (rd_x_c) begin
                snap_valid <= 1'b1;
                y_snap     <= cy[SENS_SHIFT +: 8];
            end else if (rd_y_c) begin
                snap_valid <= 1'b0;
            end
            // A press arriving with a clearing read must stay latched.
            btn_latch <= (rd_b_c ? (btn_latch & btn) : btn_latch)
                       | (event_c ? ps2_mouse[2:0] : 3'b000);
        end
    end

`ifdef KEMPSTON_WHEEL_EN
    // Wheel accumulates modulo 16.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wheel <= '0;
        end else if (event_c) begin
            wheel <= wheel + ps2_mouse_ext[3:0];
        end
    end
`endif

endmodule
